// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives PC next/enable, runs one outstanding
// imem read, arbitrates exc/eret/branch redirects and buffers under stall.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output logic        pc_en,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  input  logic        exc_valid
);

  typedef enum logic [1:0] {BOOT, IDLE, WAIT, HOLD} state_t;

  state_t      state, state_nx;
  logic        pend_v, pend_v_nx;
  logic [1:0]  pend_prio, pend_prio_nx;
  logic [31:0] pend_tgt, pend_tgt_nx;
  logic [31:0] hold_instr, hold_instr_nx;

  logic        redir_v;
  logic [1:0]  redir_prio;
  logic [31:0] redir_raw, redir_tgt, seq_pc, done_tgt;
  logic        redir_wins;

  logic [31:0] npc_c, instr_c;
  logic        pc_en_c, req_c, ifv_c;

  assign redir_v    = exc_valid | eret_valid | br_valid;
  assign redir_prio = exc_valid ? 2'd2 : (eret_valid ? 2'd1 : 2'd0);
  assign redir_raw  = exc_valid ? EXC_VECTOR : (eret_valid ? epc : br_target);
  assign redir_tgt  = {redir_raw[31:2], 2'b00};
  assign seq_pc     = pc + 32'd4;
  // On equal priority the fresh redirect replaces the pending one.
  assign redir_wins = redir_v && (!pend_v || (redir_prio >= pend_prio));
  assign done_tgt   = redir_wins ? redir_tgt : pend_tgt;

  always_comb begin
    state_nx      = state;
    pend_v_nx     = pend_v;
    pend_prio_nx  = pend_prio;
    pend_tgt_nx   = pend_tgt;
    hold_instr_nx = hold_instr;
    npc_c         = seq_pc;
    pc_en_c       = 1'b0;
    req_c         = 1'b0;
    ifv_c         = 1'b0;
    instr_c       = imem_rdata;

    case (state)
      BOOT: state_nx = IDLE;
      IDLE: begin
        if (redir_v) begin
          pc_en_c = 1'b1;
          npc_c   = redir_tgt;
        end else if (!stall) begin
          req_c    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (!imem_ack && redir_wins) begin
          pend_v_nx    = 1'b1;
          pend_prio_nx = redir_prio;
          pend_tgt_nx  = redir_tgt;
        end
      end
      HOLD: begin
        ifv_c   = 1'b1;
        instr_c = hold_instr;
        if (redir_v) begin
          ifv_c    = 1'b0;
          pc_en_c  = 1'b1;
          npc_c    = redir_tgt;
          state_nx = IDLE;
        end else if (!stall) begin
          pc_en_c  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = BOOT;
    endcase

    // Completion overrides the WAIT/IDLE decisions above.
    if (req_c && imem_ack) begin
      if (redir_v || pend_v) begin
        pc_en_c   = 1'b1;
        npc_c     = done_tgt;
        pend_v_nx = 1'b0;
        state_nx  = IDLE;
      end else if (!stall) begin
        ifv_c    = 1'b1;
        pc_en_c  = 1'b1;
        state_nx = IDLE;
      end else begin
        hold_instr_nx = imem_rdata;
        state_nx      = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pend_v     <= 1'b0;
      pend_prio  <= 2'd0;
      pend_tgt   <= 32'd0;
      hold_instr <= 32'd0;
    end else begin
      state      <= state_nx;
      pend_v     <= pend_v_nx;
      pend_prio  <= pend_prio_nx;
      pend_tgt   <= pend_tgt_nx;
      hold_instr <= hold_instr_nx;
    end
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  assign npc      = rst_n ? npc_c   : RESET_PC;
  assign pc_en    = rst_n & pc_en_c;
  assign imem_req = rst_n & req_c;
  assign if_valid = rst_n & ifv_c;
  assign if_instr = rst_n ? instr_c : 32'd0;

endmodule
